// File: rtl/hazard_forward_unit.sv
// ============================================================================
// hazard_forward_unit
//
// Purpose:
//   Producer side of the EX-stage forwarding interface. Tracks the
//   destination registers of the instructions in EX and MEM, detects RAW
//   hazards for the instruction sitting in ID, and drives EX's operand
//   forwarding selects plus the single shared Forward_data bus. Because EX
//   has only one forwarding bus, an ID instruction that needs two operands
//   from two different stages is stalled one cycle. Load-use hazards are
//   stalled the same way.
//
// Ports:
//   clk            in   pipeline clock, rising edge
//   rst            in   asynchronous active-high reset
//   id_valid       in   ID holds a real instruction
//   id_rs1/id_rs2  in   ID source registers
//   id_rs1_used    in   ID instruction reads rs1
//   id_rs2_used    in   ID instruction reads rs2
//   id_rd          in   ID destination register
//   id_we          in   ID instruction writes rd
//   id_is_load     in   ID instruction is a load
//   flush          in   taken branch/jump in EX: kill ID and EX instructions
//   mem_result     in   result of the instruction now in MEM
//   wb_result      in   result of the instruction now in WB (incl. load data)
//   stall          out  hold PC and IF/ID this cycle
//   bubble         out  load a NOP into ID/EX at the next edge
//   Forward_A_Sel  out  EX takes rs1 from Forward_data
//   Forward_B_Sel  out  EX takes rs2 from Forward_data
//   Forward_data   out  forwarded operand for EX
//
// Configuration macro:
//   HAZARD_PERF_EN  adds perf_stall_cnt (cycles with stall=1) and
//                   perf_fwd_cnt (EX cycles with any select set). Both are
//                   32-bit wrapping counters cleared by rst.
//
// Scoreboard note:
//   Only the EX and MEM slots are stored. A producer that is in WB while its
//   consumer is in ID has retired by the time the consumer reaches EX and is
//   read from the register file, so a WB slot could never affect an output.
//   For the same reason the MEM slot needs no load bit: MEM-slot producers
//   are forwarded from wb_result, which already carries load data.
// ============================================================================
module hazard_forward_unit #(
    parameter int REG_AW = 5,
    parameter int DW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic [DW-1:0]     mem_result,
    input  logic [DW-1:0]     wb_result,
    output logic              stall,
    output logic              bubble,
    output logic              Forward_A_Sel,
    output logic              Forward_B_Sel,
    output logic [DW-1:0]     Forward_data
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_fwd_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Scoreboard slots
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              ex_we_q, ex_we_d;
    logic              ex_load_q, ex_load_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_we_q, mem_we_d;

    // Forwarding state for the instruction currently in EX
    logic fwd_a_q, fwd_a_d;
    logic fwd_b_q, fwd_b_d;
    logic src_dist1_q, src_dist1_d;

    // Per-operand hit detection: index 0 is rs1, index 1 is rs2
    logic [2*REG_AW-1:0] op_rs;
    logic [1:0]          op_used;
    logic [1:0]          hit_ex;
    logic [1:0]          hit_mem;
    logic [1:0]          op_fwd;

    logic load_use;
    logic dual_src;
    logic hazard;
    logic kill_ex;

    assign op_rs   = {id_rs2, id_rs1};
    assign op_used = {id_rs2_used, id_rs1_used};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            logic [REG_AW-1:0] rs;
            logic              live;
            assign rs          = op_rs[gi*REG_AW +: REG_AW];
            // x0 is never a dependency, so rd==0 producers can never match
            assign live        = id_valid && op_used[gi] && (rs != '0);
            assign hit_ex[gi]  = live && ex_we_q  && (ex_rd_q  == rs);
            assign hit_mem[gi] = live && mem_we_q && (mem_rd_q == rs);
            assign op_fwd[gi]  = hit_ex[gi] || hit_mem[gi];
        end
    endgenerate

    // The youngest producer (EX slot) wins when both slots match, so the
    // operand's source is dist1 exactly when it hits the EX slot.
    assign load_use = (|hit_ex) && ex_load_q;
    // Two forwarded operands from different stages cannot share one bus.
    // rs1==rs2 from the same stage yields equal hit_ex bits: no conflict.
    assign dual_src = op_fwd[0] && op_fwd[1] && (hit_ex[0] != hit_ex[1]);
    assign hazard   = load_use || dual_src;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A stall lasts one cycle; back in RUN the held ID
    // instruction is re-evaluated against the advanced scoreboard, which
    // may stall it once more.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = ST_RUN;
        unique case (state_q)
            ST_RUN:   state_d = (hazard && !flush) ? ST_STALL : ST_RUN;
            ST_STALL: state_d = (hazard && !flush) ? ST_STALL : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Decisions are combinational so the stalled ID
    // instruction is held in the same cycle the hazard is seen. In STALL
    // the bubble now occupies EX, so the same hazard terms re-evaluate
    // against the advanced producers. Flush overrides any stall.
    // ------------------------------------------------------------------
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        unique case (state_q)
            ST_RUN:   stall = hazard && !flush;
            ST_STALL: stall = hazard && !flush;
            default:  stall = 1'b0;
        endcase
        bubble = stall || flush;
    end

    // ------------------------------------------------------------------
    // Scoreboard and forwarding-select next state
    // ------------------------------------------------------------------
    assign kill_ex = bubble || !id_valid;

    always_comb begin
        mem_rd_d    = ex_rd_q;
        mem_we_d    = ex_we_q;
        ex_rd_d     = '0;
        ex_we_d     = 1'b0;
        ex_load_d   = 1'b0;
        fwd_a_d     = 1'b0;
        fwd_b_d     = 1'b0;
        src_dist1_d = 1'b0;
        if (!kill_ex) begin
            ex_rd_d     = id_rd;
            ex_we_d     = id_we && (id_rd != '0);
            ex_load_d   = id_is_load && id_we;
            fwd_a_d     = op_fwd[0];
            fwd_b_d     = op_fwd[1];
            // Without a hazard both forwarded operands share one source
            src_dist1_d = |hit_ex;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rd_q     <= '0;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            fwd_a_q     <= 1'b0;
            fwd_b_q     <= 1'b0;
            src_dist1_q <= 1'b0;
        end else begin
            ex_rd_q     <= ex_rd_d;
            ex_we_q     <= ex_we_d;
            ex_load_q   <= ex_load_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            src_dist1_q <= src_dist1_d;
        end
    end

    assign Forward_A_Sel = fwd_a_q;
    assign Forward_B_Sel = fwd_b_q;
    // The source flag resets to dist2; gating wb_result during reset makes
    // the bus read zero while rst is high.
    assign Forward_data  = src_dist1_q ? mem_result : (rst ? '0 : wb_result);

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_fwd_q, perf_fwd_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, stall};
        perf_fwd_d   = perf_fwd_q + {31'd0, (fwd_a_q || fwd_b_q)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_fwd_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_fwd_q   <= perf_fwd_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_fwd_cnt   = perf_fwd_q;
`endif

endmodule
